// File: rtl/add_rca_pkg.sv
// add_rca_pkg: shared width and word type for the ripple-carry adder.
package add_rca_pkg;
  localparam int WIDTH = 32;
  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/add_rca_32_full_adder.sv
// full_adder: one-bit combinational full adder, a ripple-carry stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;
  always_comb begin
    p = a ^ b;
    s = p ^ cin;
    cout = (a & b) | (cin & p);
  end
endmodule

// File: rtl/add_rca_32.sv
// add_rca_32: 32-bit ripple-carry adder with registered sum, carry-out and valid.
// Define ADD_RCA_32_OVERFLOW_EN to add the registered signed-overflow output.
module add_rca_32
  import add_rca_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
`ifdef ADD_RCA_32_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  logic [WIDTH:0] c;
  word_t s;
  word_t sum_d, sum_q;
  logic c_out_d, c_out_q, out_valid_d, out_valid_q;
  assign c[0] = c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  always_comb begin
    sum_d = in_valid ? s : sum_q;
    c_out_d = in_valid ? c[WIDTH] : c_out_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      c_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      c_out_q <= c_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign sum = sum_q;
  assign c_out = c_out_q;
  assign out_valid = out_valid_q;
`ifdef ADD_RCA_32_OVERFLOW_EN
  logic overflow_d, overflow_q;
  always_comb overflow_d = in_valid ? (c[WIDTH] ^ c[WIDTH-1]) : overflow_q;
  always_ff @(posedge clk) overflow_q <= rst ? 1'b0 : overflow_d;
  assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_add_rca_32.sv
// tb_add_rca_32: directed and random checks of add_rca_32 against an arithmetic model.
module tb_add_rca_32;
  logic clk = 0, rst = 1;
  logic [31:0] a = 0, b = 0, sum;
  logic c_in = 0, in_valid = 0, c_out, out_valid;
  logic overflow;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_sum = 0;
  logic m_cout = 0, m_valid = 0, m_ovf = 0;
  always #5 clk = ~clk;
  add_rca_32 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .out_valid(out_valid)
`ifdef ADD_RCA_32_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );
`ifndef ADD_RCA_32_OVERFLOW_EN
  assign overflow = 1'b0;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                      input logic tv, input logic tr, input string tag);
    logic [32:0] full;
    longint sa, sb, ss;
    a = ta; b = tb_; c_in = tc; in_valid = tv; rst = tr;
    @(posedge clk);
    #1;
    full = {1'b0, ta} + {1'b0, tb_} + {32'b0, tc};
    sa = longint'($signed(ta)); sb = longint'($signed(tb_));
    ss = sa + sb + longint'(tc);
    if (tr) begin
      m_sum = 0; m_cout = 0; m_valid = 0; m_ovf = 0;
    end else begin
      m_valid = tv;
      if (tv) begin
        m_sum = full[31:0];
        m_cout = full[32];
        m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
    end
    chk({tag, ".sum"}, 64'(sum), 64'(m_sum));
    chk({tag, ".c_out"}, 64'(c_out), 64'(m_cout));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
`ifdef ADD_RCA_32_OVERFLOW_EN
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
`endif
  endtask
  initial begin
    step(32'h1234, 32'h5678, 1, 1, 1, "reset0");
    step(0, 0, 0, 0, 1, "reset1");
    step(2, 8, 0, 1, 0, "basic");
    chk("basic.abs", 64'(sum), 64'd10);
    step(32'hFFFFFFFF, 1, 0, 1, 0, "wrap");
    chk("wrap.cout_abs", 64'(c_out), 64'd1);
    step(32'h7FFFFFFF, 1, 0, 1, 0, "sovf");
    chk("sovf.abs", 64'(sum), 64'h80000000);
    step(32'hFFFFFFFB, 3, 0, 1, 0, "neg");
    chk("neg.abs", 64'(sum), 64'hFFFFFFFE);
    step(32'h80000000, 32'h80000000, 0, 1, 0, "negovf");
    step(0, 0, 1, 1, 0, "cin");
    chk("cin.abs", 64'(sum), 64'd1);
    step(32'hAAAA, 32'h5555, 1, 0, 0, "hold");
    chk("hold.abs", 64'(sum), 64'd1);
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, "allones");
    step(100, 200, 0, 1, 1, "rstmid");
    step(100, 200, 0, 1, 0, "afterrst");
    chk("afterrst.abs", 64'(sum), 64'd300);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) ra = {ra[31], {31{~ra[31]}}};
      step(ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), "rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
